muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 114 +++++++++++
 tb/tb_muldiv_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit; the division datapath is built only with MULDIV_DIV_EN
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
    state_t      state_q, state_d;
    logic [63:0] p_q, p_d, mstep, dstep, prod, pbyp;
    logic [31:0] m_q, m_d, ma, mb, fin, q, r, result_q, result_d;
    logic [2:0]  f_q, f_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        an_q, an_d, bn_q, bn_d;
    logic        sa, sb, a_neg, b_neg, byp, fin_ok;
    logic [32:0] sum, diff;

    // operand signedness, magnitudes, bypass detection and one datapath step
    always_comb begin
        sa    = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        sb    = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg = sa & a[31];
        b_neg = sb & b[31];
        ma    = a_neg ? -a : a;
        mb    = b_neg ? -b : b;
`ifdef MULDIV_DIV_EN
        byp   = funct3[2] & ((b == 32'd0) | (~funct3[0] & (a == 32'h80000000) & (b == 32'hFFFFFFFF)));
        pbyp  = (b == 32'd0) ? {a, 32'hFFFFFFFF} : {32'd0, 32'h80000000};
`else
        byp   = funct3[2];
        pbyp  = 64'd0;
`endif
        sum   = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, m_q} : 33'd0);
        mstep = {sum, p_q[31:1]};
        diff  = p_q[63:31] - {1'b0, m_q};
        dstep = diff[32] ? {p_q[62:0], 1'b0} : {diff[31:0], p_q[30:0], 1'b1};
        prod  = (an_q ^ bn_q) ? -p_q : p_q;
        q     = (an_q ^ bn_q) ? -p_q[31:0] : p_q[31:0];
        r     = an_q ? -p_q[63:32] : p_q[63:32];
`ifdef MULDIV_DIV_EN
        fin   = f_q[2] ? (f_q[1] ? r : q) : (f_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
`else
        fin   = f_q[2] ? 32'd0 : (f_q[1:0] == 2'b00 ? prod[31:0] : prod[63:32]);
`endif
        fin_ok   = (state_q == FIN) & ~kill;
        done     = fin_ok;
        busy     = state_q != IDLE;
        result_d = fin_ok ? fin : result_q;
        result   = result_d;
    end

    // next-state logic: accept, iterate 32 steps, finish; kill aborts
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        f_d     = f_q;
        an_d    = an_q;
        bn_d    = bn_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start & ~kill) begin
                f_d     = funct3;
                an_d    = a_neg & ~byp;
                bn_d    = b_neg & ~byp;
                cnt_d   = 5'd0;
                m_d     = funct3[2] ? mb : ma;
                p_d     = byp ? pbyp : (funct3[2] ? {32'd0, ma} : {32'd0, mb});
                state_d = byp ? FIN : CALC;
            end
            CALC: begin
`ifdef MULDIV_DIV_EN
                p_d     = f_q[2] ? dstep : mstep;
`else
                p_d     = mstep;
`endif
                cnt_d   = cnt_q + 5'd1;
                state_d = kill ? IDLE : (cnt_q == 5'd31 ? FIN : CALC);
            end
            default: state_d = IDLE;
        endcase
    end

    // state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            p_q      <= 64'd0;
            m_q      <= 32'd0;
            f_q      <= 3'd0;
            an_q     <= 1'b0;
            bn_q     <= 1'b0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            p_q      <= p_d;
            m_q      <= m_d;
            f_q      <= f_d;
            an_q     <= an_d;
            bn_q     <= bn_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic RV32M reference model
module tb_muldiv_unit;
    logic        clk = 1'b0, reset = 1'b0, start = 1'b0, kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] a = 32'd0, b = 32'd0;
    logic        busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0, bad = 0, cyc = 0;
    logic [31:0] last_res = 32'd0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] sx, sy, zx, zy, p;
        int si, sj;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        zx = {32'd0, x};
        zy = {32'd0, y};
        si = x;
        sj = y;
        model = 32'd0;
        if (!f[2]) begin
            case (f[1:0])
                2'd0: p = zx * zy;
                2'd1: p = sx * sy;
                2'd2: p = sx * zy;
                default: p = zx * zy;
            endcase
            model = (f[1:0] == 2'd0) ? p[31:0] : p[63:32];
        end else begin
`ifdef MULDIV_DIV_EN
            if (y == 32'd0) model = f[1] ? x : 32'hFFFFFFFF;
            else if (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) model = f[1] ? 32'd0 : 32'h80000000;
            else case (f[1:0])
                2'd0: model = si / sj;
                2'd1: model = x / y;
                2'd2: model = si % sj;
                default: model = x % y;
            endcase
`else
            model = 32'd0;
`endif
        end
    endfunction

    function automatic int lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_DIV_EN
        lat = (f[2] && (y == 32'd0 || (!f[0] && x == 32'h80000000 && y == 32'hFFFFFFFF))) ? 1 : 33;
`else
        lat = f[2] ? 1 : 33;
`endif
    endfunction

    // monitor: every done pulse is matched against the oldest expected response
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done actual=done result=%h required=no done", result);
            end else begin
                e = sb_q.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", cyc, e.cyc);
                last_res = e.res;
            end
        end
    end

    task automatic issue(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        @(negedge clk);
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        e.res  = model(f, x, y);
        e.cyc  = cyc + lat(f, x, y);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        funct3 = 3'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL done_timeout actual=no done required=done within 60 cycles");
            sb_q.delete();
        end else begin
            @(negedge clk);
            chk("busy_after_done", 32'(busy), 32'd0);
        end
    endtask

    task automatic op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        issue(f, x, y);
        wait_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int nd;
        logic [2:0]  f;
        logic [31:0] x, y;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        reset = 1'b1;

        op(3'd0, 32'd7, 32'hFFFFFFFD);
        op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        op(3'd4, 32'hFFFFFFF9, 32'd2);
        op(3'd6, 32'hFFFFFFF9, 32'd2);
        op(3'd5, 32'd5, 32'd0);
        op(3'd6, 32'h80000000, 32'hFFFFFFFF);
        op(3'd4, 32'h80000000, 32'hFFFFFFFF);
        op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);

        issue(3'd0, 32'd12345, 32'd678);
        repeat (10) @(negedge clk);
        kill  = 1'b1;
        start = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("kill_busy", 32'(busy), 32'd0);
        chk("kill_result", result, last_res);
        kill  = 1'b0;
        start = 1'b0;
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("kill_no_done", 32'(nd), 32'd0);
        op(3'd1, 32'h89ABCDEF, 32'h12345678);

        issue(3'd3, 32'hDEADBEEF, 32'hCAFEF00D);
        repeat (32) @(negedge clk);
        @(posedge clk);
        #1;
        kill = 1'b1;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("kill_fin_done", 32'(done), 32'd0);
        chk("kill_fin_result", result, last_res);
        @(posedge clk);
        #1;
        kill = 1'b0;
        @(negedge clk);
        chk("kill_fin_busy", 32'(busy), 32'd0);

        @(negedge clk);
        start  = 1'b1;
        kill   = 1'b1;
        funct3 = 3'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        kill  = 1'b0;
        @(negedge clk);
        chk("kill_over_start_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);

        issue(3'd0, 32'd99, 32'd101);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        void'(sb_q.pop_back());
        @(negedge clk);
        chk("midcalc_reset_busy", 32'(busy), 32'd0);
        chk("midcalc_reset_done", 32'(done), 32'd0);
        chk("midcalc_reset_result", result, 32'd0);
        reset    = 1'b1;
        last_res = 32'd0;

        issue(3'd2, 32'h80000001, 32'h7FFFFFFF);
        start = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            a      = $urandom;
            b      = $urandom;
            funct3 = 3'($urandom);
        end
        start = 1'b0;
        wait_done();

        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 7))
                0: y = 32'd0;
                1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
                2: begin x = 32'($urandom_range(0, 50)); y = 32'($urandom_range(1, 9)); end
                3: x = 32'h80000000;
                default: ;
            endcase
            op(f, x, y);
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
